// File: rtl/div_if.sv
// Handshake and operand bundle between the EX stage and the iterative divider.
interface div_if;
  logic        start;
  logic        flush;
  logic [4:0]  select;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] result;
  logic        busy;
  logic        done;

  modport master (output start, flush, select, data1, data2,
                  input  result, busy, done);
  modport slave  (input  start, flush, select, data1, data2,
                  output result, busy, done);
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional feature: DIV_EARLY_OUT_EN lets divide-by-zero and signed overflow bypass CALC.
module div_unit (
  input  logic clk,
  input  logic reset,
  div_if.slave dif
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] result_r;

  logic [31:0] quo, rem, dvs, a_raw;
  logic        is_rem, neg_q, neg_r, div0, ovf;

  logic signed [31:0] a_s, b_s;
  logic        sel_ok, sgn_op, a_neg, b_neg, in_div0, in_ovf, special;
  logic        accept, early, last;
  logic [32:0] rem_sh, diff;
  logic [31:0] quo_nxt, rem_nxt;

  function automatic logic [31:0] fix_quo(input logic [31:0] q, input logic neg,
                                          input logic z, input logic o);
    if (z)        fix_quo = 32'hFFFF_FFFF;
    else if (o)   fix_quo = 32'h8000_0000;
    else if (neg) fix_quo = -q;
    else          fix_quo = q;
  endfunction

  function automatic logic [31:0] fix_rem(input logic [31:0] r, input logic neg,
                                          input logic z, input logic o,
                                          input logic [31:0] dividend);
    if (z)        fix_rem = dividend;
    else if (o)   fix_rem = 32'h0;
    else if (neg) fix_rem = -r;
    else          fix_rem = r;
  endfunction

  always_comb begin
    a_s     = dif.data1;
    b_s     = dif.data2;
    sel_ok  = (dif.select[4:2] == 3'b111);
    sgn_op  = ~dif.select[1];
    a_neg   = sgn_op & (a_s < 0);
    b_neg   = sgn_op & (b_s < 0);
    in_div0 = (dif.data2 == 32'h0);
    in_ovf  = sgn_op && (dif.data1 == 32'h8000_0000) && (dif.data2 == 32'hFFFF_FFFF);
    special = in_div0 | in_ovf;
    accept  = (state == IDLE) && dif.start && !dif.flush && sel_ok;
`ifdef DIV_EARLY_OUT_EN
    early   = accept && special;
`else
    early   = 1'b0;
`endif
    last    = (state == CALC) && (cnt == 6'd0) && !dif.flush;
  end

  // one restoring step: shift in next dividend bit, keep difference if non-negative
  always_comb begin
    rem_sh  = {rem, quo[31]};
    diff    = rem_sh - {1'b0, dvs};
    quo_nxt = {quo[30:0], ~diff[32]};
    rem_nxt = diff[32] ? rem_sh[31:0] : diff[31:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = early ? FIN : CALC;
      CALC: begin
        if (dif.flush)          state_nxt = IDLE;
        else if (cnt == 6'd0)   state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      result_r <= 32'h0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= 6'd31;
      else if (state == CALC && (dif.flush || cnt == 6'd0))
        cnt <= 6'd0;
      else if (state == CALC)
        cnt <= cnt - 6'd1;

      if (early)
        result_r <= dif.select[0] ? fix_rem(32'h0, 1'b0, in_div0, in_ovf, dif.data1)
                                  : fix_quo(32'h0, 1'b0, in_div0, in_ovf);
      else if (last)
        result_r <= is_rem ? fix_rem(rem_nxt, neg_r, div0, ovf, a_raw)
                           : fix_quo(quo_nxt, neg_q, div0, ovf);
    end
  end

  // operand/working registers carry no reset; they are always loaded on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      quo    <= a_neg ? -dif.data1 : dif.data1;
      rem    <= 32'h0;
      dvs    <= b_neg ? -dif.data2 : dif.data2;
      a_raw  <= dif.data1;
      is_rem <= dif.select[0];
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      div0   <= in_div0;
      ovf    <= in_ovf;
    end else if (state == CALC) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
    end
  end

  assign dif.result = result_r;
  assign dif.busy   = (state == CALC);
  assign dif.done   = (state == FIN);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit with hand-computed expectations.
module tb_div_unit;

  localparam logic [4:0] OP_DIV  = 5'b11100;
  localparam logic [4:0] OP_REM  = 5'b11101;
  localparam logic [4:0] OP_DIVU = 5'b11110;
  localparam logic [4:0] OP_REMU = 5'b11111;
`ifdef DIV_EARLY_OUT_EN
  localparam int SPC_LAT = 1;
`else
  localparam int SPC_LAT = 33;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  div_if dif();

  div_unit dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat, input bit poke,
                       input string tag);
    int lat;
    @(negedge clk);
    dif.start = 1'b1; dif.select = sel; dif.data1 = a; dif.data2 = b;
    @(negedge clk);
    dif.start = 1'b0;
    dif.data1 = $urandom; dif.data2 = $urandom;
    check({tag, " busy"}, {31'b0, dif.busy}, (exp_lat != 1) ? 32'd1 : 32'd0);
    lat = 1;
    while (!dif.done && lat < 100) begin
      dif.start = poke && (lat == 5);
      dif.select = OP_REMU;
      @(negedge clk);
      lat++;
    end
    dif.start = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, dif.result, exp_res);
    @(negedge clk);
    check({tag, " done pulse"}, {31'b0, dif.done}, 32'd0);
  endtask

  initial begin
    int cyc;
    int dcnt;
    logic [31:0] prev;
    dif.start = 1'b0; dif.flush = 1'b0; dif.select = 5'b0;
    dif.data1 = 32'h0; dif.data2 = 32'h0;

    repeat (3) @(negedge clk);
    check("reset result", dif.result, 32'h0);
    check("reset busy", {31'b0, dif.busy}, 32'd0);
    check("reset done", {31'b0, dif.done}, 32'd0);
    reset = 1'b0;

    do_op(OP_DIV,  32'd100, 32'd7, 32'd14, 33, 1'b0, "div 100/7");
    do_op(OP_REM,  32'd100, 32'd7, 32'd2,  33, 1'b0, "rem 100/7");
    do_op(OP_DIV,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33, 1'b0, "div -20/3");
    do_op(OP_REM,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33, 1'b0, "rem -20/3");
    do_op(OP_DIVU, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, 33, 1'b0, "divu fffffffe/2");
    do_op(OP_REMU, 32'd27, 32'd5, 32'd2, 33, 1'b0, "remu 27/5");
    do_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0, "div 7/-2");
    do_op(OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0, "rem 7/-2");
    do_op(OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, SPC_LAT, 1'b0, "div 5/0");
    do_op(OP_REM,  32'd5, 32'd0, 32'd5, SPC_LAT, 1'b0, "rem 5/0");
    do_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPC_LAT, 1'b0, "divu 5/0");
    do_op(OP_REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, SPC_LAT, 1'b0, "rem -7/0");
    do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT, 1'b0, "div ovf");
    do_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SPC_LAT, 1'b0, "rem ovf");
    do_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33, 1'b0, "divu 80000000/ffffffff");
    do_op(OP_DIV,  32'd100, 32'd7, 32'd14, 33, 1'b1, "div with extra start");

    // flush at cycle 10 of an operation
    prev = dif.result;
    @(negedge clk);
    dif.start = 1'b1; dif.select = OP_DIV; dif.data1 = 32'd100; dif.data2 = 32'd7;
    @(negedge clk);
    dif.start = 1'b0;
    for (cyc = 1; cyc < 10; cyc++) @(negedge clk);
    dif.flush = 1'b1;
    @(negedge clk);
    dif.flush = 1'b0;
    check("flush busy", {31'b0, dif.busy}, 32'd0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.done) dcnt++;
    end
    check("flush no done", dcnt, 0);
    check("flush result held", dif.result, prev);
    do_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b0, "divu 9/3 after flush");

    // asynchronous reset at cycle 15
    @(negedge clk);
    dif.start = 1'b1; dif.select = OP_DIV; dif.data1 = 32'd100; dif.data2 = 32'd7;
    @(negedge clk);
    dif.start = 1'b0;
    for (cyc = 1; cyc < 15; cyc++) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midop reset result", dif.result, 32'h0);
    check("midop reset busy", {31'b0, dif.busy}, 32'd0);
    check("midop reset done", {31'b0, dif.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.done) dcnt++;
    end
    check("no done after reset", dcnt, 0);

    // invalid select is ignored
    @(negedge clk);
    dif.start = 1'b1; dif.select = 5'b00000; dif.data1 = 32'd100; dif.data2 = 32'd7;
    @(negedge clk);
    dif.start = 1'b0;
    check("bad select busy", {31'b0, dif.busy}, 32'd0);
    check("bad select done", {31'b0, dif.done}, 32'd0);
    repeat (3) @(negedge clk);
    check("bad select result", dif.result, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
